// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the switch SRAM controller: header field offsets
// and the ingress write FSM state encoding.
package sram_ctl_pkg;

  localparam int unsigned DES_PORT_LSB = 0;
  localparam int unsigned DES_PORT_W   = 4;
  localparam int unsigned PRI_LSB      = 4;
  localparam int unsigned PRI_W        = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRecv    = 2'd1,
    StDiscard = 2'd2
  } wr_state_e;

endpackage

// File: rtl/ingress_fifo_mem.sv
// Register array for the ingress buffer: one synchronous write port and one
// combinational (show-ahead) read port.
module ingress_fifo_mem #(
  parameter int unsigned width      = 66,
  parameter int unsigned depth      = 64,
  parameter int unsigned addr_width = 6
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [addr_width-1:0] i_waddr,
  input  logic [width-1:0]      i_wdata,
  input  logic [addr_width-1:0] i_raddr,
  output logic [width-1:0]      o_rdata
);

  logic [width-1:0] r_mem [depth];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ingress_port_buffer.sv
// Per-port store-and-forward ingress buffer; drops packets that do not fit whole.
// Define INGRESS_DROP_CNT_EN to build the saturating dropped-packet counter.
module ingress_port_buffer
  import sram_ctl_pkg::*;
#(
  parameter int unsigned data_width = 64,
  parameter int unsigned fifo_depth = 64,
  parameter int unsigned addr_width = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_vld,
  input  logic [data_width-1:0] wr_data,
  input  logic                  next_data,
  output logic                  ready,
  output logic                  sop,
  output logic                  eop,
  output logic                  vld,
  output logic [data_width-1:0] data_out,
  output logic [addr_width:0]   free_words,
  output logic                  drop_pulse,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned PtrW = addr_width + 1;
  localparam logic [addr_width:0] DepthP = PtrW'(fifo_depth);

  wr_state_e             r_state, w_state_d;
  logic [addr_width:0]   r_rd_ptr, r_wr_ptr, r_commit_ptr, r_pkt_cnt;
  logic [addr_width:0]   w_wr_ptr_d, w_commit_ptr_d, w_base, w_occ;
  logic                  r_drop_pulse;
  logic                  w_we, w_commit, w_drop;
  logic                  w_vld, w_pop, w_pop_eop;
  logic [data_width+1:0] w_rdata;
  logic                  w_rd_sop, w_rd_eop;
  logic [data_width-1:0] w_rd_data;

  // A new packet always starts at the commit point, which also rolls back a truncated one.
  assign w_base = wr_sop ? r_commit_ptr : r_wr_ptr;
  assign w_occ  = w_base - r_rd_ptr;

  always_comb begin
    w_state_d      = r_state;
    w_wr_ptr_d     = r_wr_ptr;
    w_commit_ptr_d = r_commit_ptr;
    w_we           = 1'b0;
    w_commit       = 1'b0;
    w_drop         = 1'b0;
    if (wr_vld) begin
      if (wr_sop || (r_state == StRecv)) begin
        if (wr_sop && (r_state == StRecv)) w_drop = 1'b1;
        if (w_occ == DepthP) begin
          w_drop     = 1'b1;
          w_wr_ptr_d = r_commit_ptr;
          w_state_d  = wr_eop ? StIdle : StDiscard;
        end else begin
          w_we       = 1'b1;
          w_wr_ptr_d = w_base + 1'b1;
          if (wr_eop) begin
            w_commit       = 1'b1;
            w_commit_ptr_d = w_base + 1'b1;
            w_state_d      = StIdle;
          end else begin
            w_state_d = StRecv;
          end
        end
      end else if ((r_state == StDiscard) && wr_eop) begin
        w_state_d = StIdle;
      end
    end
  end

  ingress_fifo_mem #(
    .width      (data_width + 2),
    .depth      (fifo_depth),
    .addr_width (addr_width)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_base[addr_width-1:0]),
    .i_wdata ({wr_sop, wr_eop, wr_data}),
    .i_raddr (r_rd_ptr[addr_width-1:0]),
    .o_rdata (w_rdata)
  );

  assign {w_rd_sop, w_rd_eop, w_rd_data} = w_rdata;

  assign w_vld     = (r_rd_ptr != r_commit_ptr);
  assign w_pop     = next_data & w_vld;
  assign w_pop_eop = w_pop & w_rd_eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pkt_cnt    <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_commit_ptr <= w_commit_ptr_d;
      r_drop_pulse <= w_drop;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_commit && !w_pop_eop)      r_pkt_cnt <= r_pkt_cnt + 1'b1;
      else if (!w_commit && w_pop_eop) r_pkt_cnt <= r_pkt_cnt - 1'b1;
    end
  end

  assign vld        = w_vld;
  assign ready      = (r_pkt_cnt != '0);
  assign sop        = w_vld & w_rd_sop;
  assign eop        = w_vld & w_rd_eop;
  assign data_out   = w_vld ? w_rd_data : '0;
  assign free_words = DepthP - (r_wr_ptr - r_rd_ptr);
  assign drop_pulse = r_drop_pulse;

`ifdef INGRESS_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ingress_port_buffer.sv
// Scoreboard bench for ingress_port_buffer: a packet-level queue model predicts
// the committed word stream; a negedge monitor pops and compares on each DUT pop.
module tb_ingress_port_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
`ifdef INGRESS_DROP_CNT_EN
  localparam bit DCNT_EN = 1'b1;
`else
  localparam bit DCNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_sop = 1'b0, wr_eop = 1'b0, wr_vld = 1'b0, next_data = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          ready, sop, eop, vld, drop_pulse;
  logic [DW-1:0] data_out;
  logic [AW:0]   free_words;
  logic [15:0]   drop_cnt;

  ingress_port_buffer #(
    .data_width (DW),
    .fifo_depth (DEPTH),
    .addr_width (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .wr_vld     (wr_vld),
    .wr_data    (wr_data),
    .next_data  (next_data),
    .ready      (ready),
    .sop        (sop),
    .eop        (eop),
    .vld        (vld),
    .data_out   (data_out),
    .free_words (free_words),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          s;
    logic          e;
    logic [DW-1:0] d;
  } word_t;

  // Model: exp_q = committed unread words, pend_q = packet in progress.
  // mode 0 = between packets, 1 = receiving, 2 = discarding rest of a packet.
  word_t exp_q[$], pend_q[$], s_pend_q[$];
  int    m_mode = 0, s_mode = 0, m_pkts = 0, m_dcnt = 0;
  bit    m_drop = 0, s_drop = 0, s_commit = 0, s_rst = 1;
  int    n_checks = 0, n_pass = 0;
  bit    mon_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  // Make the effects of the previous clock edge visible in the model.
  task automatic apply_staged();
    if (s_rst) begin
      exp_q.delete();
      pend_q.delete();
      m_mode = 0;
      m_pkts = 0;
      m_drop = 0;
      m_dcnt = 0;
    end else begin
      m_drop = s_drop;
      if (s_drop && DCNT_EN && m_dcnt < 65535) m_dcnt++;
      m_mode = s_mode;
      if (s_commit) begin
        foreach (s_pend_q[i]) exp_q.push_back(s_pend_q[i]);
        m_pkts++;
        pend_q.delete();
      end else begin
        pend_q = s_pend_q;
      end
    end
  endtask

  // Predict what the coming edge does with the current inputs.
  task automatic decide();
    word_t w;
    s_rst    = rst;
    s_drop   = 0;
    s_commit = 0;
    s_mode   = m_mode;
    s_pend_q = pend_q;
    if (rst || !wr_vld) return;
    w.s = wr_sop;
    w.e = wr_eop;
    w.d = wr_data;
    if (wr_sop) begin
      if (m_mode == 1) s_drop = 1;
      s_pend_q.delete();
      if (exp_q.size() >= DEPTH) begin
        s_drop = 1;
        s_mode = wr_eop ? 0 : 2;
      end else begin
        s_pend_q.push_back(w);
        s_commit = wr_eop;
        s_mode   = wr_eop ? 0 : 1;
      end
    end else if (m_mode == 1) begin
      if (exp_q.size() + pend_q.size() >= DEPTH) begin
        s_drop = 1;
        s_pend_q.delete();
        s_mode = wr_eop ? 0 : 2;
      end else begin
        s_pend_q.push_back(w);
        s_commit = wr_eop;
        if (wr_eop) s_mode = 0;
      end
    end else if (m_mode == 2 && wr_eop) begin
      s_mode = 0;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic e, input logic v,
                       input logic [DW-1:0] d, input logic nd);
    @(posedge clk);
    #1;
    apply_staged();
    rst = r; wr_sop = s; wr_eop = e; wr_vld = v; wr_data = d; next_data = nd;
    decide();
  endtask

  task automatic idle(input int n, input logic nd);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, nd);
  endtask

  task automatic pkt(input int len, input logic [DW-1:0] base, input logic nd);
    for (int i = 0; i < len; i++)
      drive(1'b0, i == 0, i == len - 1, 1'b1, base + DW'(i), nd);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      word_t w;
      chk("vld", vld, exp_q.size() != 0);
      chk("ready", ready, m_pkts != 0);
      chk("free_words", free_words, DEPTH - exp_q.size() - pend_q.size());
      chk("drop_pulse", drop_pulse, m_drop);
      chk("drop_cnt", drop_cnt, m_dcnt);
      if (!vld) begin
        chk("idle_data", data_out, 0);
        chk("idle_flags", {sop, eop}, 0);
      end else if (exp_q.size() != 0) begin
        chk("head_data", data_out, exp_q[0].d);
        chk("head_flags", {sop, eop}, {exp_q[0].s, exp_q[0].e});
      end
      if (vld && next_data && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (w.e) m_pkts--;
      end
    end
  end

  function automatic int rand_len();
    return ($urandom_range(0, 7) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 12);
  endfunction

  initial begin
    int rem = 0;
    int nd_pct = 70;
    int len;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    mon_en = 1;

    // Single 4-word packet, then popped back to back.
    idle(1, 1'b0);
    pkt(4, 64'h100, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);
    idle(2, 1'b0);

    // Fill with 60 words, then a 10-word packet that overflows on word 5.
    pkt(60, 64'h1000, 1'b0);
    pkt(10, 64'h2000, 1'b0);
    idle(2, 1'b0);
    idle(70, 1'b1);

    // Truncation by an early sop, replaced by a 2-word packet.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h300, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h301, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h302, 1'b0);
    pkt(2, 64'h310, 1'b0);
    idle(6, 1'b1);

    // Pop A's eop in the same cycle B's eop commits.
    pkt(2, 64'hA0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'hB0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'hB1, 1'b1);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Reset with two committed packets and one in progress.
    pkt(2, 64'h500, 1'b0);
    pkt(3, 64'h510, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h520, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_free", free_words, DEPTH);
    chk("rst_vld", vld, 0);
    idle(1, 1'b0);

    // Three truncations in a row.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h600, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h601, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h602, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h603, 1'b0);
    idle(1, 1'b0);
    chk("drop_cnt_3", drop_cnt, DCNT_EN ? 3 : 0);
    idle(4, 1'b1);

    // Randomized traffic with throttled popping and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      logic nd;
      if (c % 300 == 0) nd_pct = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(30, 100);
      nd = ($urandom_range(0, 99) < nd_pct);
      if ($urandom_range(0, 1499) == 0) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rem = 0;
      end else if (rem == 0) begin
        int r = $urandom_range(0, 9);
        if (r < 3) begin
          drive(1'b0, 1'b0, $urandom_range(0, 1), r == 0, {$urandom, $urandom}, nd);
        end else begin
          len = rand_len();
          drive(1'b0, 1'b1, len == 1, 1'b1, {$urandom, $urandom}, nd);
          rem = len - 1;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, nd);
      end else if ($urandom_range(0, 49) == 0) begin
        len = rand_len();
        drive(1'b0, 1'b1, len == 1, 1'b1, {$urandom, $urandom}, nd);
        rem = len - 1;
      end else begin
        drive(1'b0, 1'b0, rem == 1, 1'b1, {$urandom, $urandom}, nd);
        rem--;
      end
    end

    // Finish any open packet, then drain.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'hE0F, 1'b1);
    idle(200, 1'b1);
    chk("drained_vld", vld, 0);
    chk("drained_ready", ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ingress_port_buffer.md
# ingress_port_buffer

- Per-port store-and-forward ingress buffer; one instance per switch port sits directly upstream of `write_arbiter`.
- Accepts the external write stream (`wr_sop`/`wr_eop`/`wr_vld`/`wr_data`).
- Stores complete packets and presents them word by word to the arbiter (`ready`/`sop`/`eop`/`vld`/data), advancing on the arbiter's `next_data` pulse.
- Packets that do not fit are dropped whole, so the arbiter never sees a partial packet.

## Interface
- `data_width`, default 64: word width. Header word bits [3:0] hold the destination port and bits [6:4] hold the priority; this block passes them through untouched.
- `fifo_depth`, default 64: storage depth in words; maximum packet length.
- `addr_width`, default 6: equals log2(`fifo_depth`).
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `wr_sop`, input, 1: first word of the incoming packet.
- `wr_eop`, input, 1: last word of the incoming packet.
- `wr_vld`, input, 1: `wr_data` valid this cycle.
- `wr_data`, input, `data_width`: incoming word.
- `next_data`, input, 1: arbiter pop strobe, one word per cycle.
- `ready`, output, 1: at least one complete packet is stored.
- `sop`, output, 1: head word is a packet start.
- `eop`, output, 1: head word is a packet end.
- `vld`, output, 1: head word is valid and belongs to a committed packet.
- `data_out`, output, `data_width`: head word (show-ahead).
- `free_words`, output, `addr_width`+1: words not occupied by committed data or the packet in progress.
- `drop_pulse`, output, 1: one-cycle pulse per dropped packet.
- `drop_cnt`, output, 16: dropped-packet counter.

## Operation
- **Storage:** circular array of `data_width`+2 bits per word, holding data plus the sop and eop flags.
- **Pointers:**
  - `rd_ptr`: read pointer.
  - `wr_ptr`: working write pointer.
  - `commit_ptr`: end of the last complete packet.
  - `pkt_cnt`: committed packets not yet fully popped.
- **Write FSM states:** IDLE, RECV, DISCARD.
- **IDLE:**
  - `wr_vld & wr_sop` writes the word and advances `wr_ptr`.
  - If `wr_eop` is also high, the packet commits immediately and the FSM stays in IDLE; otherwise it goes to RECV.
  - `wr_vld` without `wr_sop` is ignored.
- **RECV:**
  - `wr_vld` writes the word.
  - `wr_eop` commits the packet: `commit_ptr <= wr_ptr+1`, `pkt_cnt++`, next state IDLE.
  - `wr_vld & wr_sop` means the previous packet is truncated: rollback `wr_ptr <= commit_ptr`, `drop_pulse`, then the new packet starts at `commit_ptr` as in IDLE.
- **Overflow:**
  - A write when occupancy (`wr_ptr`−`rd_ptr`) equals `fifo_depth` is refused.
  - On a refused write: `wr_ptr <= commit_ptr`, `drop_pulse`, next state DISCARD.
  - If the refused word carried `wr_eop`, next state is IDLE instead.
- **DISCARD:**
  - Words are ignored until `wr_eop`, then the FSM returns to IDLE.
  - `wr_sop` in DISCARD starts a new packet as in IDLE.
- **Read side:**
  - `vld` = (`rd_ptr` != `commit_ptr`).
  - `ready` = (`pkt_cnt` != 0).
  - `sop`/`eop`/`data_out` come from `mem[rd_ptr]` and are 0 when `vld` = 0.
  - `next_data` with `vld` = 1 advances `rd_ptr`; `next_data` with `vld` = 0 is ignored.
  - Popping an eop word decrements `pkt_cnt`.
- **Simultaneous events:**
  - Commit and eop-pop in the same cycle leave `pkt_cnt` unchanged.
  - Write and pop in the same cycle are both performed.
  - A pop frees space for a write in the following cycle, not the same cycle.
- **Arithmetic:** pointers are `addr_width`+1 bits and wrap modulo 2·`fifo_depth`; the MSB distinguishes full from empty.

## Timing
- **Reset values:**
  - All pointers 0, `pkt_cnt` 0, FSM in IDLE.
  - `ready`/`sop`/`eop`/`vld`/`drop_pulse` = 0, `data_out` = 0.
  - `free_words` = `fifo_depth`, `drop_cnt` = 0.
- **Write-to-ready latency:** eop written at edge N gives `ready` = 1 from cycle N+1.
- **Pop timing:** `next_data` sampled at edge N gives the new head on `data_out` from cycle N+1. Back-to-back pops at one word per cycle are supported.
- **Drop timing:** `drop_pulse` is registered and asserted in the cycle after the refusing or truncating edge.
- **Reset mid-operation:** all stored and partial packets are discarded; no `drop_pulse` is generated.

## Configuration
- **`INGRESS_DROP_CNT_EN` defined:** `drop_cnt` increments on each `drop_pulse`, saturates at 16'hFFFF, and clears only on `rst`.
- **`INGRESS_DROP_CNT_EN` undefined:** `drop_cnt` is tied to 0 and no counter register exists. `drop_pulse` is present in both builds.

## Structure
- **Shared package `sram_ctl_pkg`:**
  - Header field offsets (`DES_PORT_LSB` = 0, `DES_PORT_W` = 4, `PRI_LSB` = 4, `PRI_W` = 3).
  - Write FSM state encoding.
- **Sub-module `ingress_fifo_mem`:** dual-pointer register array with one synchronous write port and one combinational read port. The FSM and pointers stay in the top level.

## Test plan
1. 4-word packet, then 3 idle cycles: `ready` = 1 one cycle after eop; `sop` = 1 on word 0 and `eop` = 1 on word 3 while popped with continuous `next_data`; `ready` = 0 and `pkt_cnt` = 0 after the 4th pop.
2. Fill with a 60-word packet unpopped, then a 10-word packet: overflow on the 5th word of the second packet gives `drop_pulse`, `free_words` = 4, remaining words ignored, and only the 60-word packet is readable.
3. `wr_sop` at word 3 of an unfinished packet: `drop_pulse`, then the new 2-word packet is committed; the readout shows only the new packet.
4. Pop the eop of packet A while packet B's eop is written in the same cycle: `pkt_cnt` stays 1 and `ready` stays 1.
5. `rst` asserted mid-packet with 2 committed packets: next cycle all outputs are at reset values, `free_words` = 64, and `drop_cnt` = 0.
6. Build with `INGRESS_DROP_CNT_EN` and force 3 drops: `drop_cnt` = 3. Without the macro: `drop_cnt` = 0.
